// File: rtl/indent_token_sequencer.sv
// Turns per-line indentation records and lexer tokens into one output token stream,
// inserting INDENT/DEDENT tokens and closing all open levels before EOF.
module indent_token_sequencer #(
  parameter int unsigned KIND_W       = 5,
  parameter int unsigned PAYLOAD_W    = 32,
  parameter int unsigned COL_W        = 8,
  parameter int unsigned LEVEL_W      = 4,
  parameter int unsigned KIND_INDENT  = 16,
  parameter int unsigned KIND_DEDENT  = 17,
  parameter int unsigned KIND_NEWLINE = 18,
  parameter int unsigned KIND_EOF     = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bol_valid,
  output logic                 bol_ready,
  input  logic [COL_W-1:0]     bol_cols,
  input  logic                 bol_blank,
  input  logic                 bol_eof,
  input  logic                 lx_valid,
  output logic                 lx_ready,
  input  logic [KIND_W-1:0]    lx_kind,
  input  logic [PAYLOAD_W-1:0] lx_payload,
  output logic                 tok_valid,
  input  logic                 tok_ready,
  output logic [KIND_W-1:0]    tok_kind,
  output logic [PAYLOAD_W-1:0] tok_payload,
  output logic [LEVEL_W-1:0]   depth,
  output logic                 err_indent,
  output logic                 err_depth
);

  localparam int unsigned MaxLevel = (1 << LEVEL_W) - 1;

  typedef enum logic [2:0] {
    StBol, StIndent, StDedent, StPass, StFlush, StDone, StErr
  } state_e;

  state_e              state;
  logic [LEVEL_W-1:0]  target;
  logic                line_empty;
  logic                load_ok;
  logic [COL_W-3:0]    bol_level;
  logic                bol_over;
  logic [LEVEL_W-1:0]  bol_target;

  assign load_ok    = !tok_valid || tok_ready;
  assign bol_ready  = (state == StBol);
  assign lx_ready   = (state == StPass) && load_ok;
  assign bol_level  = bol_cols[COL_W-1:2];
  assign bol_over   = 32'(bol_level) > MaxLevel;
  assign bol_target = LEVEL_W'(bol_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StBol;
      target      <= '0;
      line_empty  <= 1'b1;
      tok_valid   <= 1'b0;
      tok_kind    <= '0;
      tok_payload <= '0;
      depth       <= '0;
      err_indent  <= 1'b0;
      err_depth   <= 1'b0;
    end else begin
      // Drained entry clears; any load below in the same cycle overrides this.
      if (tok_valid && tok_ready) begin
        tok_valid   <= 1'b0;
        tok_kind    <= '0;
        tok_payload <= '0;
      end
      case (state)
        StBol: begin
          if (bol_valid) begin
            if (bol_eof) begin
              state <= StFlush;
            end else if (bol_blank) begin
              state <= StBol;
            end else if (bol_cols[1:0] != 2'b00) begin
              err_indent <= 1'b1;
              state      <= StErr;
            end else if (bol_over) begin
              err_depth <= 1'b1;
              state     <= StErr;
            end else begin
              target     <= bol_target;
              line_empty <= 1'b1;
              if (bol_target > depth)      state <= StIndent;
              else if (bol_target < depth) state <= StDedent;
              else                         state <= StPass;
            end
          end
        end
        StIndent: begin
          if (load_ok) begin
            tok_valid   <= 1'b1;
            tok_kind    <= KIND_W'(KIND_INDENT);
            tok_payload <= '0;
            depth       <= depth + LEVEL_W'(1);
            if ((depth + LEVEL_W'(1)) == target) state <= StPass;
          end
        end
        StDedent: begin
          if (load_ok) begin
            tok_valid   <= 1'b1;
            tok_kind    <= KIND_W'(KIND_DEDENT);
            tok_payload <= '0;
            depth       <= depth - LEVEL_W'(1);
            if ((depth - LEVEL_W'(1)) == target) state <= StPass;
          end
        end
        StPass: begin
          if (lx_valid && load_ok) begin
            if (lx_kind == KIND_W'(KIND_EOF)) begin
              state <= StFlush;
            end else if (lx_kind == KIND_W'(KIND_NEWLINE)) begin
              // A NEWLINE before any real token is a no-op line terminator.
              if (!line_empty) begin
                tok_valid   <= 1'b1;
                tok_kind    <= lx_kind;
                tok_payload <= lx_payload;
                state       <= StBol;
              end
            end else begin
              tok_valid   <= 1'b1;
              tok_kind    <= lx_kind;
              tok_payload <= lx_payload;
              line_empty  <= 1'b0;
            end
          end
        end
        StFlush: begin
          if (load_ok) begin
            tok_valid   <= 1'b1;
            tok_payload <= '0;
            if (depth != '0) begin
              tok_kind <= KIND_W'(KIND_DEDENT);
              depth    <= depth - LEVEL_W'(1);
            end else begin
              tok_kind <= KIND_W'(KIND_EOF);
              state    <= StDone;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

endmodule

// File: tb/tb_indent_token_sequencer.sv
// Randomized and directed bench for indent_token_sequencer against a line-level model
// that derives the expected token list from indentation counts.
module tb_indent_token_sequencer;

  localparam logic [4:0] KInd = 5'd16;
  localparam logic [4:0] KDed = 5'd17;
  localparam logic [4:0] KNl  = 5'd18;
  localparam logic [4:0] KEof = 5'd19;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bol_valid, bol_ready, bol_blank, bol_eof;
  logic [7:0]  bol_cols;
  logic        lx_valid, lx_ready;
  logic [4:0]  lx_kind;
  logic [31:0] lx_payload;
  logic        tok_valid, tok_ready;
  logic [4:0]  tok_kind;
  logic [31:0] tok_payload;
  logic [3:0]  depth;
  logic        err_indent, err_depth;

  always #5 clk = ~clk;

  indent_token_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bol_valid  (bol_valid),
    .bol_ready  (bol_ready),
    .bol_cols   (bol_cols),
    .bol_blank  (bol_blank),
    .bol_eof    (bol_eof),
    .lx_valid   (lx_valid),
    .lx_ready   (lx_ready),
    .lx_kind    (lx_kind),
    .lx_payload (lx_payload),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_kind   (tok_kind),
    .tok_payload(tok_payload),
    .depth      (depth),
    .err_indent (err_indent),
    .err_depth  (err_depth)
  );

  typedef struct {
    bit          is_bol;
    logic [7:0]  cols;
    bit          blank;
    bit          eof;
    logic [4:0]  kind;
    logic [31:0] payload;
  } stim_t;

  typedef struct {
    logic [4:0]  kind;
    logic [31:0] payload;
  } tok_t;

  stim_t stim_q[$];
  tok_t  exp_q[$];
  int    m_depth;
  bit    m_empty;
  int    checks = 0;
  int    errors = 0;
  int    first_fire, last_fire, nfires;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [4:0] k, input logic [31:0] p);
    tok_t t;
    t.kind = k;
    t.payload = p;
    exp_q.push_back(t);
  endtask

  task automatic model_flush();
    repeat (m_depth) exp_push(KDed, 32'd0);
    m_depth = 0;
    exp_push(KEof, 32'd0);
  endtask

  task automatic q_bol(input int cols, input bit blank, input bit eof);
    stim_t s;
    int t;
    s = '{is_bol: 1'b1, cols: 8'(cols), blank: blank, eof: eof, kind: 5'd0, payload: 32'd0};
    stim_q.push_back(s);
    if (eof) model_flush();
    else if (!blank) begin
      t = cols / 4;
      while (m_depth < t) begin exp_push(KInd, 32'd0); m_depth++; end
      while (m_depth > t) begin exp_push(KDed, 32'd0); m_depth--; end
      m_empty = 1'b1;
    end
  endtask

  task automatic q_lx(input logic [4:0] k, input logic [31:0] p);
    stim_t s;
    s = '{is_bol: 1'b0, cols: 8'd0, blank: 1'b0, eof: 1'b0, kind: k, payload: p};
    stim_q.push_back(s);
    if (k == KEof) model_flush();
    else if (k == KNl) begin
      if (!m_empty) exp_push(k, p);
    end else begin
      exp_push(k, p);
      m_empty = 1'b0;
    end
  endtask

  task automatic drive_idle();
    bol_valid = 1'b0; bol_cols = 8'd0; bol_blank = 1'b0; bol_eof = 1'b0;
    lx_valid = 1'b0; lx_kind = 5'd0; lx_payload = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    tok_ready = 1'b1;
    stim_q.delete();
    exp_q.delete();
    m_depth = 0;
    m_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_stream(input bit full_rate, input int budget);
    int n = 0;
    bit prev_stall = 1'b0;
    bit fire;
    logic [4:0]  pk = '0;
    logic [31:0] pp = '0;
    tok_t e;
    stim_t h;
    nfires = 0;
    while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      tok_ready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive_idle();
      if (stim_q.size() != 0 && (full_rate || $urandom_range(0, 4) != 0)) begin
        h = stim_q[0];
        if (h.is_bol) begin
          bol_valid = 1'b1; bol_cols = h.cols; bol_blank = h.blank; bol_eof = h.eof;
        end else begin
          lx_valid = 1'b1; lx_kind = h.kind; lx_payload = h.payload;
        end
      end
      #1;
      if (prev_stall) begin
        check("stall_kind", 64'(tok_kind), 64'(pk));
        check("stall_payload", 64'(tok_payload), 64'(pp));
      end
      if (tok_valid && !tok_ready) check("stall_lx_ready", 64'(lx_ready), 64'd0);
      prev_stall = tok_valid && !tok_ready;
      pk = tok_kind;
      pp = tok_payload;
      if (tok_valid && tok_ready) begin
        if (exp_q.size() == 0) check("extra_token", 64'(tok_valid), 64'd0);
        else begin
          e = exp_q.pop_front();
          check("tok_kind", 64'(tok_kind), 64'(e.kind));
          check("tok_payload", 64'(tok_payload), 64'(e.payload));
        end
        if (nfires == 0) first_fire = n;
        last_fire = n;
        nfires++;
      end
      fire = (bol_valid && bol_ready) || (lx_valid && lx_ready);
      @(posedge clk);
      if (fire) void'(stim_q.pop_front());
    end
    check("stream_drained", 64'(stim_q.size() + exp_q.size()), 64'd0);
    @(negedge clk);
    drive_idle();
    tok_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("no_extra_token", 64'(tok_valid), 64'd0);
  endtask

  initial begin
    int n;
    int lines;
    rst_n = 1'b0;
    tok_ready = 1'b0;
    drive_idle();
    m_depth = 0;
    m_empty = 1'b1;
    #3;
    check("rst_tok_valid", 64'(tok_valid), 64'd0);
    check("rst_tok_kind", 64'(tok_kind), 64'd0);
    check("rst_tok_payload", 64'(tok_payload), 64'd0);
    check("rst_depth", 64'(depth), 64'd0);
    check("rst_errs", 64'({err_indent, err_depth}), 64'd0);
    check("rst_bol_ready", 64'(bol_ready), 64'd1);
    check("rst_lx_ready", 64'(lx_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat line, full rate.
    q_bol(0, 1'b0, 1'b0);
    q_lx(5'd1, 32'd7); q_lx(5'd2, 32'd0); q_lx(5'd3, 32'd42); q_lx(KNl, 32'd0);
    run_stream(1'b1, 50);
    check("flat_count", 64'(nfires), 64'd4);
    check("flat_rate", 64'(last_fire - first_fire), 64'd3);
    check("flat_bol_ready", 64'(bol_ready), 64'd1);

    // Two levels in.
    q_bol(8, 1'b0, 1'b0);
    q_lx(5'd1, 32'd5); q_lx(KNl, 32'd0);
    run_stream(1'b1, 50);
    check("indent_rate", 64'(last_fire - first_fire), 64'd3);
    check("indent_depth", 64'(depth), 64'd2);

    // Back to zero with a held first DEDENT.
    @(negedge clk);
    bol_valid = 1'b1; bol_cols = 8'd0; tok_ready = 1'b1;
    @(negedge clk);
    drive_idle();
    n = 0;
    while (!tok_valid && n < 5) begin @(negedge clk); n++; end
    tok_ready = 1'b0;
    repeat (3) begin
      #1;
      check("hold_kind", 64'(tok_valid ? tok_kind : 5'd0), 64'(KDed));
      check("hold_depth", 64'(depth), 64'd1);
      check("hold_lx_ready", 64'(lx_ready), 64'd0);
      @(negedge clk);
    end
    tok_ready = 1'b1;
    @(negedge clk);
    #1;
    check("second_dedent", 64'(tok_valid ? tok_kind : 5'd0), 64'(KDed));
    check("second_depth", 64'(depth), 64'd0);
    @(negedge clk);
    #1 check("dedent_no_dup", 64'(tok_valid), 64'd0);
    m_depth = 0;
    m_empty = 1'b1;
    q_lx(KEof, 32'd0);
    run_stream(1'b0, 50);
    check("done_readies", 64'({bol_ready, lx_ready}), 64'd0);

    // Misaligned indentation.
    do_reset();
    bol_valid = 1'b1; bol_cols = 8'd6;
    @(negedge clk);
    bol_valid = 1'b1; bol_cols = 8'd0; lx_valid = 1'b1; lx_kind = 5'd1;
    repeat (3) begin
      #1;
      check("ei_flag", 64'({err_indent, err_depth}), 64'b10);
      check("ei_readies", 64'({bol_ready, lx_ready, tok_valid}), 64'd0);
      @(negedge clk);
    end

    // Too deep, then the deepest legal level.
    do_reset();
    bol_valid = 1'b1; bol_cols = 8'd64;
    @(negedge clk);
    drive_idle();
    #1;
    check("ed_flag", 64'({err_indent, err_depth}), 64'b01);
    check("ed_readies", 64'({bol_ready, lx_ready, tok_valid}), 64'd0);
    do_reset();
    q_bol(60, 1'b0, 1'b0); q_lx(KEof, 32'd0);
    run_stream(1'b0, 400);

    // Blank line at depth 3, then lexer EOF.
    do_reset();
    q_bol(12, 1'b0, 1'b0); q_lx(5'd4, 32'hABCD); q_lx(KNl, 32'd0);
    q_bol(3, 1'b1, 1'b0);
    q_bol(12, 1'b0, 1'b0); q_lx(5'd6, 32'd1); q_lx(KEof, 32'd0);
    run_stream(1'b0, 400);
    check("eof_depth", 64'(depth), 64'd0);
    check("eof_done_readies", 64'({bol_ready, lx_ready}), 64'd0);

    // Async reset during the second of four INDENTs.
    do_reset();
    bol_valid = 1'b1; bol_cols = 8'd16;
    @(negedge clk);
    drive_idle();
    n = 0;
    while (depth != 4'd2 && n < 10) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_tok_valid", 64'(tok_valid), 64'd0);
    check("arst_depth", 64'(depth), 64'd0);
    check("arst_bol_ready", 64'(bol_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stim_q.delete(); exp_q.delete(); m_depth = 0; m_empty = 1'b1;
    q_bol(4, 1'b0, 1'b0); q_lx(5'd1, 32'd9); q_lx(KNl, 32'd0);
    run_stream(1'b0, 100);
    check("arst_after_depth", 64'(depth), 64'd1);

    // Random programs.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      lines = $urandom_range(3, 8);
      for (int l = 0; l < lines; l++) begin
        if ($urandom_range(0, 4) == 0) q_bol($urandom_range(0, 255), 1'b1, 1'b0);
        else begin
          q_bol(4 * $urandom_range(0, 15), 1'b0, 1'b0);
          if ($urandom_range(0, 2) == 0) q_lx(KNl, $urandom);
          for (int k = 0; k < $urandom_range(1, 4); k++)
            q_lx(5'($urandom_range(0, 15)), $urandom);
          q_lx(KNl, $urandom);
        end
      end
      if ($urandom_range(0, 1) == 0) q_bol($urandom_range(0, 255), 1'b0, 1'b1);
      else begin
        q_bol(4 * $urandom_range(0, 15), 1'b0, 1'b0);
        q_lx(5'($urandom_range(0, 15)), $urandom);
        q_lx(KEof, 32'd0);
      end
      run_stream(1'b0, 3000);
      check("rand_done_readies", 64'({bol_ready, lx_ready}), 64'd0);
      check("rand_depth", 64'(depth), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
